// File: rtl/crack_dispatch.sv
// crack_dispatch: hands candidate keys 0,1,2,... to NUM_CORES crack engines
// and collects their results. The smallest matching key is reported, so the
// answer equals a sequential search whatever the core count or latencies.
module crack_dispatch #(
   parameter int NUM_CORES = 2,
   parameter int KEY_W     = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   output logic                 rdy,
   output logic [KEY_W-1:0]     key,
   output logic                 key_valid,
   output logic [NUM_CORES-1:0] core_en,
   output logic [KEY_W-1:0]     core_key,
   input  logic [NUM_CORES-1:0] core_rdy,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_match
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t               state_r, state_s;
   // One extra bit so the counter reaching 2^KEY_W marks exhaustion instead of wrapping.
   logic [KEY_W:0]       next_key_r, next_key_s;
   logic [NUM_CORES-1:0] outstanding_r, outstanding_s;
   logic                 found_r, found_s;
   logic [KEY_W-1:0]     best_r, best_s;
   logic [KEY_W-1:0]     key_r, key_s;
   logic                 key_valid_r, key_valid_s;
   logic [KEY_W-1:0]     issued_key_r [NUM_CORES];

   logic [NUM_CORES-1:0] cand_s;
   logic [NUM_CORES-1:0] issue_oh_s;
   logic                 issue_s;
   logic [NUM_CORES-1:0] done_ok_s;
   logic                 take_s;
   logic                 found_c_s;
   logic [KEY_W-1:0]     best_c_s;
   logic                 last_key_s;
   logic                 finish_s;

   // Pick the lowest-index idle core that is not already holding a key.
   always_comb begin
      cand_s     = core_rdy & ~outstanding_r &
                   {NUM_CORES{(state_r == ST_RUN) && !next_key_r[KEY_W]}};
      issue_oh_s = {NUM_CORES{1'b0}};
      issue_s    = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         issue_oh_s[i] = cand_s[i] & ~issue_s;
         issue_s       = issue_s | cand_s[i];
      end
   end

   // Fold this cycle's completions into the running minimum matching key.
   always_comb begin
      done_ok_s = core_done & outstanding_r;
      found_c_s = found_r;
      best_c_s  = best_r;
      take_s    = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         take_s    = done_ok_s[i] & core_match[i] &
                     (~found_c_s | (issued_key_r[i] < best_c_s));
         best_c_s  = take_s ? issued_key_r[i] : best_c_s;
         found_c_s = found_c_s | take_s;
      end
   end

   // Next-state and result update for the IDLE/RUN/DRAIN sequencer.
   always_comb begin
      state_s       = state_r;
      next_key_s    = next_key_r;
      found_s       = found_c_s;
      best_s        = best_c_s;
      key_s         = key_r;
      key_valid_s   = key_valid_r;
      finish_s      = 1'b0;
      outstanding_s = (outstanding_r & ~done_ok_s) | issue_oh_s;
      last_key_s    = issue_s && (next_key_r[KEY_W-1:0] == {KEY_W{1'b1}});
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_s     = ST_RUN;
               next_key_s  = {(KEY_W+1){1'b0}};
               found_s     = 1'b0;
               key_valid_s = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_s) begin
               next_key_s = next_key_r + {{KEY_W{1'b0}}, 1'b1};
            end else begin
               next_key_s = next_key_r;
            end
            if (found_c_s || last_key_s || next_key_r[KEY_W]) begin
               if (outstanding_s == {NUM_CORES{1'b0}}) begin
                  state_s  = ST_IDLE;
                  finish_s = 1'b1;
               end else begin
                  state_s = ST_DRAIN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (outstanding_s == {NUM_CORES{1'b0}}) begin
               state_s  = ST_IDLE;
               finish_s = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // Every smaller key has completed once nothing is outstanding, so publish now.
      key_valid_s = finish_s ? found_c_s : key_valid_s;
      key_s       = (finish_s && found_c_s) ? best_c_s : key_s;
   end

   // Control and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         next_key_r    <= {(KEY_W+1){1'b0}};
         outstanding_r <= {NUM_CORES{1'b0}};
         found_r       <= 1'b0;
         best_r        <= {KEY_W{1'b0}};
         key_r         <= {KEY_W{1'b0}};
         key_valid_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         next_key_r    <= next_key_s;
         outstanding_r <= outstanding_s;
         found_r       <= found_s;
         best_r        <= best_s;
         key_r         <= key_s;
         key_valid_r   <= key_valid_s;
      end
   end

   // Remember which key each core is working on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            issued_key_r[i] <= {KEY_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            issued_key_r[i] <= issue_oh_s[i] ? next_key_r[KEY_W-1:0] : issued_key_r[i];
         end
      end
   end

   assign rdy       = (state_r == ST_IDLE);
   assign key       = key_r;
   assign key_valid = key_valid_r;
   assign core_en   = issue_oh_s;
   assign core_key  = issue_s ? next_key_r[KEY_W-1:0] : {KEY_W{1'b0}};

endmodule

// File: tb/tb_crack_dispatch.sv
// Self-checking bench for crack_dispatch: behavioural crack-engine models plus
// a transaction-level reference of the dispatch rules.
module tb_crack_dispatch;
   localparam int NC = 4;
   localparam int KW = 6;
   localparam int NK = 1 << KW;

   logic          clk = 1'b0;
   logic          rst_n, en, rdy, key_valid;
   logic [KW-1:0] key, core_key;
   logic [NC-1:0] core_en, core_rdy, core_done, core_match;

   always #5 clk = ~clk;

   crack_dispatch #(.NUM_CORES(NC), .KEY_W(KW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .core_en(core_en), .core_key(core_key), .core_rdy(core_rdy),
      .core_done(core_done), .core_match(core_match)
   );

   int checks = 0;
   int passed = 0;

   // stimulus configuration and engine models
   logic [NK-1:0] match_set;
   logic [NC-1:0] active;
   int            lat [NC];
   int            stall_pct, spur_pct;
   bit            c_busy [NC];
   int            c_cnt [NC];
   logic [KW-1:0] c_key [NC];
   bit            en_req, rst_req;
   int            log_core [$];
   int            log_key [$];

   // reference state
   bit            r_search, r_found, r_kv;
   logic [NC-1:0] r_out;
   logic [KW-1:0] r_issued [NC];
   logic [KW-1:0] r_best, r_key;
   int            r_next;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int min_match(input logic [NK-1:0] s);
      for (int k = 0; k < NK; k++) if (s[k]) return k;
      return -1;
   endfunction

   // One clock: drive inputs on the falling edge, check, then advance the models.
   task automatic cycle();
      logic [NC-1:0] d, m, rv, exp_en;
      bit was_busy;
      int exp_i, j;
      @(negedge clk);
      rst_n = rst_req;
      en    = en_req;
      d = '0; m = '0;
      for (int i = 0; i < NC; i++) begin
         if (c_busy[i]) begin
            c_cnt[i]--;
            if (c_cnt[i] == 0) begin
               c_busy[i] = 0; d[i] = 1'b1; m[i] = match_set[c_key[i]];
            end
         end
      end
      if (spur_pct > 0 && $urandom_range(99) < spur_pct) begin
         j = $urandom_range(NC-1);
         if (!c_busy[j] && !d[j]) begin d[j] = 1'b1; m[j] = 1'b1; end
      end
      for (int i = 0; i < NC; i++)
         rv[i] = active[i] && !c_busy[i] && !(stall_pct > 0 && $urandom_range(99) < stall_pct);
      core_rdy = rv; core_done = d; core_match = m;
      #1;
      if (!rst_n) begin
         r_search = 0; r_out = '0; r_found = 0; r_kv = 0; r_key = '0; r_next = 0;
      end
      was_busy = r_search || (r_out != '0);
      exp_en = '0; exp_i = -1;
      if (rst_n && r_search && r_next < NK)
         for (int i = 0; i < NC; i++) if (exp_i < 0 && rv[i] && !r_out[i]) exp_i = i;
      if (exp_i >= 0) exp_en[exp_i] = 1'b1;
      chk("rdy", rdy, !was_busy);
      chk("core_en", core_en, exp_en);
      if (exp_i >= 0) chk("core_key", core_key, r_next);
      chk("key_valid", key_valid, r_kv);
      chk("key", key, r_key);
      for (int i = 0; i < NC; i++) begin
         if (core_en[i]) begin
            c_busy[i] = 1; c_cnt[i] = lat[i]; c_key[i] = core_key;
            log_core.push_back(i); log_key.push_back(int'(core_key));
         end
      end
      if (rst_n) begin
         for (int i = 0; i < NC; i++) begin
            if (d[i] && r_out[i]) begin
               r_out[i] = 1'b0;
               if (m[i]) begin
                  if (!r_found || r_issued[i] < r_best) r_best = r_issued[i];
                  r_found = 1; r_search = 0;
               end
            end
         end
         if (exp_i >= 0) begin
            r_out[exp_i] = 1'b1; r_issued[exp_i] = r_next[KW-1:0];
            if (r_next == NK-1) r_search = 0;
            r_next++;
         end
         if (!was_busy && en) begin
            r_search = 1; r_next = 0; r_found = 0; r_kv = 0;
         end else if (was_busy && !r_search && r_out == '0) begin
            r_kv = r_found;
            if (r_found) r_key = r_best;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((r_search || r_out != '0) && n < 4000) begin cycle(); n++; end
      chk("search_timeout", (r_search || r_out != '0), 0);
   endtask

   task automatic run_search(input string name);
      int mm;
      logic [KW-1:0] exp_key;
      mm = min_match(match_set);
      exp_key = (mm >= 0) ? mm[KW-1:0] : r_key;
      en_req = 1'b1; cycle(); en_req = 1'b0;
      wait_idle();
      cycle();
      chk({name, "_valid"}, key_valid, (mm >= 0));
      chk({name, "_key"}, key, exp_key);
   endtask

   initial begin
      int ord;
      int exp_c [4] = '{0, 1, 0, 1};
      rst_n = 1'b0; en = 1'b0; core_rdy = '0; core_done = '0; core_match = '0;
      rst_req = 1'b0; en_req = 1'b0; stall_pct = 0; spur_pct = 0;
      active = 4'b0011; match_set = '0;
      for (int i = 0; i < NC; i++) begin lat[i] = 10; c_busy[i] = 0; c_cnt[i] = 0; c_key[i] = '0; end
      r_search = 0; r_out = '0; r_found = 0; r_kv = 0; r_key = '0; r_best = '0; r_next = 0;
      for (int i = 0; i < NC; i++) r_issued[i] = '0;

      // reset state
      repeat (2) cycle();
      chk("rst_rdy", rdy, 1); chk("rst_kv", key_valid, 0);
      chk("rst_key", key, 0); chk("rst_core_en", core_en, 0);
      rst_req = 1'b1;
      repeat (2) cycle();

      // two cores, equal latency, match at 3
      match_set[3] = 1'b1;
      log_core.delete(); log_key.delete();
      run_search("t1");
      chk("t1_nissue", (log_core.size() >= 4), 1);
      for (int k = 0; k < 4 && k < log_core.size(); k++) begin
         chk("t1_order_core", log_core[k], exp_c[k]);
         chk("t1_order_key", log_key[k], k);
      end
      chk("t1_lit_key", key, 6'h03); chk("t1_lit_kv", key_valid, 1);

      // unequal latency: larger match reported first
      lat[0] = 40; lat[1] = 5; match_set = '0; match_set[6'h10] = 1'b1; match_set[6'h13] = 1'b1;
      run_search("t2");
      chk("t2_lit_key", key, 6'h10);

      // no match: every key exactly once, no wrap
      lat[0] = 3; lat[1] = 2; match_set = '0;
      log_core.delete(); log_key.delete();
      run_search("t3");
      repeat (5) cycle();
      ord = 0;
      foreach (log_key[k]) if (log_key[k] == k) ord++;
      chk("t3_issues", log_key.size(), NK); chk("t3_in_order", ord, NK);
      chk("t3_kv", key_valid, 0); chk("t3_key_held", key, 6'h10);

      // simultaneous completions: core1 holds key1, core0 holds key2; spurious dones
      lat[0] = 4; lat[1] = 8; match_set = '0; match_set[1] = 1'b1; match_set[2] = 1'b1;
      spur_pct = 30;
      run_search("t4");
      chk("t4_lit_key", key, 6'h01);
      repeat (10) cycle();
      spur_pct = 0;

      // reset mid-search, then restart from key 0
      lat[0] = 10; lat[1] = 10; match_set = '0;
      en_req = 1'b1; cycle(); en_req = 1'b0;
      repeat (15) cycle();
      rst_req = 1'b0; cycle();
      chk("midrst_core_en", core_en, 0); chk("midrst_rdy", rdy, 1); chk("midrst_kv", key_valid, 0);
      cycle(); rst_req = 1'b1;
      repeat (30) cycle();
      match_set[5] = 1'b1;
      log_core.delete(); log_key.delete();
      run_search("t5");
      chk("t5_first_key", (log_key.size() > 0) ? log_key[0] : -1, 0);

      // en while busy ignored; repeat run gives same result
      lat[0] = 7; lat[1] = 7;
      en_req = 1'b1; cycle(); en_req = 1'b0;
      repeat (3) cycle();
      en_req = 1'b1; repeat (3) cycle(); en_req = 1'b0;
      wait_idle(); cycle();
      chk("t6_key", key, 6'h05); chk("t6_kv", key_valid, 1);
      run_search("t6b");
      chk("t6b_key", key, 6'h05);

      // randomized rounds over all four cores
      stall_pct = 20; spur_pct = 10;
      for (int r = 0; r < 20; r++) begin
         active = 4'($urandom_range(15));
         if (active == '0) active = 4'b1000;
         for (int i = 0; i < NC; i++) lat[i] = $urandom_range(12, 1);
         match_set = '0;
         for (int n = $urandom_range(3); n > 0; n--) match_set[$urandom_range(NK-1)] = 1'b1;
         run_search("rnd");
         repeat ($urandom_range(4)) cycle();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
